// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS ADC receive path: aligner FSM encoding,
// per-family frame words and counter-width helpers.
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SLIP   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  // Frame-clock words seen when the ISERDES boundary sits on the frame edge.
  localparam logic [7:0] FRAME_2LANE_S8 = 8'hF0;
  localparam logic [6:0] FRAME_2LANE_S7 = 7'h78;
  localparam logic [5:0] FRAME_2LANE_S6 = 6'h38;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sample bit position fed by lane l, serial bit k (k=0 is the first bit received).
  function automatic int lane_bit_pos(input int k, input int l, input int lanes, input int s);
    return (lanes * s) - 1 - (k * lanes + l);
  endfunction

endpackage

// File: rtl/lane_deinterleave.sv
// Combinational re-mapping of one channel's lane words into a full-width
// sample: serial bit k of lane l lands at sample bit W-1-(k*LANES+l).
module lane_deinterleave
  import lvds_rx_pkg::*;
#(
  parameter int S     = 8,
  parameter int LANES = 2
) (
  input  logic [LANES*S-1:0] i_lanes,
  output logic [LANES*S-1:0] o_sample
);

  // Pure wiring; the parent registers the result.
  always_comb begin
    o_sample = '0;
    for (int k = 0; k < S; k++) begin
      for (int l = 0; l < LANES; l++) begin
        o_sample[lane_bit_pos(k, l, LANES, S)] = i_lanes[l*S + (S-1-k)];
      end
    end
  end

endmodule

// File: rtl/lvds_frame_aligner.sv
// Closed-loop bitslip aligner for frame-clocked LVDS ADC lanes, plus
// per-channel sample reassembly with a lock-qualified valid flag.
module lvds_frame_aligner
  import lvds_rx_pkg::*;
#(
  parameter int             S             = 8,
  parameter int             LANES         = 2,
  parameter int             N_CH          = 1,
  parameter logic [S-1:0]   FRAME_PATTERN = S'(FRAME_2LANE_S8),
  parameter int             SETTLE        = 16,
  parameter int             LOCK_COUNT    = 64,
  parameter int             MISS_LIMIT    = 4
) (
  input  logic                        sample_clk,
  input  logic                        reset,
  input  logic                        realign,
  input  logic [S-1:0]                frame_in,
  input  logic [N_CH*LANES*S-1:0]     data_in,
  output logic                        bitslip,
  output logic                        locked,
  output logic                        align_err,
  output logic [$clog2(S)-1:0]        slip_count,
  output logic [N_CH*LANES*S-1:0]     samples_out,
  output logic                        sample_valid
);

  localparam int W        = LANES * S;
  localparam int SETTLE_W = cnt_w(SETTLE);
  localparam int MATCH_W  = cnt_w(LOCK_COUNT);
  localparam int MISS_W   = cnt_w(MISS_LIMIT);
  localparam int SLIP_W   = $clog2(S);

  align_state_t               r_state;
  logic [SETTLE_W-1:0]        r_settle_cnt;
  logic [MATCH_W-1:0]         r_match_cnt;
  logic [MISS_W-1:0]          r_miss_cnt;
  logic [SLIP_W-1:0]          r_slip_cnt;
  logic                       r_bitslip;
  logic                       r_locked;
  logic                       r_align_err;
  logic [N_CH*W-1:0]          r_samples;
  logic                       r_sample_valid;

  logic                       w_frame_match;
  logic                       w_slip_wrap;
  logic [SLIP_W-1:0]          w_slip_next;
  logic [N_CH*W-1:0]          w_samples;

  assign w_frame_match = (frame_in == FRAME_PATTERN);
  assign w_slip_wrap   = (r_slip_cnt == SLIP_W'(S-1));
  assign w_slip_next   = w_slip_wrap ? '0 : (r_slip_cnt + SLIP_W'(1));

  // Slip/settle/check/lock sequencer; realign overrides any frame decision.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_bitslip    <= 1'b0;
      r_locked     <= 1'b0;
      r_align_err  <= 1'b0;
    end else if (realign) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_bitslip    <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_W'(SETTLE-1)) begin
            r_settle_cnt <= '0;
            r_state      <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_frame_match) begin
            if (r_match_cnt == MATCH_W'(LOCK_COUNT-1)) begin
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
              r_locked    <= 1'b1;
              r_state     <= ST_LOCKED;
            end else begin
              r_match_cnt <= r_match_cnt + MATCH_W'(1);
            end
          end else begin
            // Slip is counted on entry so slip_count and the pulse appear together.
            r_match_cnt <= '0;
            r_bitslip   <= 1'b1;
            r_slip_cnt  <= w_slip_next;
            if (w_slip_wrap) begin
              r_align_err <= 1'b1;
            end
            r_state     <= ST_SLIP;
          end
        end
        ST_SLIP: begin
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_LOCKED: begin
          if (w_frame_match) begin
            r_miss_cnt <= '0;
          end else if (r_miss_cnt == MISS_W'(MISS_LIMIT-1)) begin
            // Losing lock starts a fresh sweep: count restarts, this slip is its first.
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_bitslip   <= 1'b1;
            r_slip_cnt  <= SLIP_W'(1);
            r_state     <= ST_SLIP;
          end else begin
            r_miss_cnt <= r_miss_cnt + MISS_W'(1);
          end
        end
        default: begin
          r_state      <= ST_SETTLE;
          r_settle_cnt <= '0;
          r_match_cnt  <= '0;
          r_miss_cnt   <= '0;
          r_locked     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lane_deinterleave #(
      .S     (S),
      .LANES (LANES)
    ) u_deint (
      .i_lanes  (data_in[c*W +: W]),
      .o_sample (w_samples[c*W +: W])
    );
  end

  // Sample register; valid trails locked by one cycle to line up with the data.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      r_samples      <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_samples      <= w_samples;
      r_sample_valid <= r_locked;
    end
  end

  assign bitslip      = r_bitslip;
  assign locked       = r_locked;
  assign align_err    = r_align_err;
  assign slip_count   = r_slip_cnt;
  assign samples_out  = r_samples;
  assign sample_valid = r_sample_valid;

endmodule
